// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Groups the streaming signals of the RV32I instruction encoder.
//   Input side : clr, in_valid/in_ready, opcode, rd, rs1, rs2, funct3,
//                funct7, imm (XLEN bits, signed, unpacked).
//   Output side: out_valid/out_ready, out_instr (32), out_addr (ADDR_W),
//                err_valid, err_code (2), word_count (16).
// Modports:
//   slave  - the encoder's view (consumes fields, produces words).
//   master - the view of whoever drives fields and consumes words.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_valid;
    logic [1:0]        err_code;
    logic [15:0]       word_count;

    modport slave (
        input  clr, in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr,
        output err_valid, err_code, word_count
    );

    modport master (
        output clr, in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr,
        input  err_valid, err_code, word_count
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I instruction encoder (inverse of an immediate generator).
// Decoded fields are captured into S1, where the format is decoded, the
// immediate is range checked and the word is packed. Legal words move into
// the S2 output register together with a sequential write address; illegal
// entries are dropped and reported through err_valid/err_code.
// Ports:
//   clk   - rising-edge clock
//   rstn  - asynchronous active-low reset
//   bus   - instr_encoder_if.slave (fields in, words/address/errors out)
// A field set presented with in_valid & in_ready in cycle N appears with
// out_valid in cycle N+2 when out_ready is not holding the pipe.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int                XLEN      = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rstn,
    instr_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_OPC   = 2'd3;

    // Ready gate: low during reset and until the first clock after release.
    logic              run_q;

    // S1: raw fields of the entry being decoded.
    logic              s1_full;
    logic [6:0]        s1_opcode;
    logic [4:0]        s1_rd;
    logic [4:0]        s1_rs1;
    logic [4:0]        s1_rs2;
    logic [2:0]        s1_funct3;
    logic [6:0]        s1_funct7;
    logic [XLEN-1:0]   s1_imm;

    fmt_t              s1_fmt;
    logic [1:0]        s1_err;
    logic [31:0]       s1_word;

    // S2 and status registers.
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              err_valid_q;
    logic [1:0]        err_code_q;
    logic [15:0]       word_count_q;

    logic              s2_loads;
    logic              in_ready_c;
    logic              accept;
    logic              handshake;
    logic              s1_good;
    logic              s1_bad;

    // True when every bit above 'top' is a copy of bit 'top', i.e. the value
    // is the sign extension of v[top:0].
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int top);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < XLEN; i++) begin
            if (i > top && v[i] != v[top]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign s2_loads   = !out_valid_q || bus.out_ready;
    assign in_ready_c = run_q && !bus.clr && (!s1_full || s2_loads);
    assign accept     = bus.in_valid && in_ready_c;
    assign handshake  = out_valid_q && bus.out_ready;
    assign s1_good    = s1_full && (s1_err == ERR_NONE);
    assign s1_bad     = s1_full && (s1_err != ERR_NONE);

    // Opcode to instruction format.
    always_comb begin
        s1_fmt = FMT_NONE;
        case (s1_opcode)
            7'b0110011:                         s1_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: s1_fmt = FMT_I;
            7'b0100011:                         s1_fmt = FMT_S;
            7'b1100011:                         s1_fmt = FMT_B;
            7'b0110111, 7'b0010111:             s1_fmt = FMT_U;
            7'b1101111:                         s1_fmt = FMT_J;
            default:                            s1_fmt = FMT_NONE;
        endcase
    end

    // Range check and bit scatter. For B/J the alignment check takes
    // priority over the range check. I-type shifts need no special case:
    // imm[11:5] carries the funct7-like bits straight through.
    always_comb begin
        s1_err  = ERR_NONE;
        s1_word = '0;
        case (s1_fmt)
            FMT_R: begin
                s1_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            end
            FMT_I: begin
                if (!fits_signed(s1_imm, 11)) begin
                    s1_err = ERR_RANGE;
                end
                s1_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            end
            FMT_S: begin
                if (!fits_signed(s1_imm, 11)) begin
                    s1_err = ERR_RANGE;
                end
                s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3,
                           s1_imm[4:0], s1_opcode};
            end
            FMT_B: begin
                if (s1_imm[0]) begin
                    s1_err = ERR_ALIGN;
                end else if (!fits_signed(s1_imm, 12)) begin
                    s1_err = ERR_RANGE;
                end
                s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                           s1_imm[4:1], s1_imm[11], s1_opcode};
            end
            FMT_U: begin
                if (|s1_imm[11:0]) begin
                    s1_err = ERR_RANGE;
                end
                s1_word = {s1_imm[31:12], s1_rd, s1_opcode};
            end
            FMT_J: begin
                if (s1_imm[0]) begin
                    s1_err = ERR_ALIGN;
                end else if (!fits_signed(s1_imm, 20)) begin
                    s1_err = ERR_RANGE;
                end
                s1_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                           s1_rd, s1_opcode};
            end
            default: begin
                s1_err = ERR_OPC;
            end
        endcase
    end

    // in_ready stays low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // S1 capture. An accept can only happen when S1 is empty or leaving,
    // so a new capture always replaces an entry that has moved on.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_full   <= 1'b0;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
        end else if (bus.clr) begin
            s1_full <= 1'b0;
        end else if (accept) begin
            s1_full   <= 1'b1;
            s1_opcode <= bus.opcode;
            s1_rd     <= bus.rd;
            s1_rs1    <= bus.rs1;
            s1_rs2    <= bus.rs2;
            s1_funct3 <= bus.funct3;
            s1_funct7 <= bus.funct7;
            s1_imm    <= bus.imm;
        end else if (s2_loads) begin
            s1_full <= 1'b0;
        end
    end

    // S2 output register. out_instr only changes when a legal word lands,
    // so it is stable while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
        end else if (bus.clr) begin
            out_valid_q <= 1'b0;
        end else if (s2_loads) begin
            out_valid_q <= s1_good;
            if (s1_good) begin
                out_instr_q <= s1_word;
            end
        end
    end

    // Error reporting: a rejected entry is dropped as S1 advances and
    // raises a one-cycle pulse; the code is held until the next rejection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
        end else if (bus.clr) begin
            err_valid_q <= 1'b0;
        end else begin
            err_valid_q <= s2_loads && s1_bad;
            if (s2_loads && s1_bad) begin
                err_code_q <= s1_err;
            end
        end
    end

    // Write address and delivered-word count follow the output handshake;
    // both wrap naturally at their register widths.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_addr_q   <= BASE_ADDR;
            word_count_q <= '0;
        end else if (bus.clr) begin
            out_addr_q   <= BASE_ADDR;
            word_count_q <= '0;
        end else if (handshake) begin
            out_addr_q   <= out_addr_q + ADDR_W'(4);
            word_count_q <= word_count_q + 16'd1;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_instr  = out_instr_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.err_valid  = err_valid_q;
    assign bus.err_code   = err_code_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Bench for instr_encoder: directed encodings, error cases, backpressure,
// clr, asynchronous reset mid-stream, address wrap (second instance with a
// 4-bit address) and a randomized stream scored against a reference model
// that builds words from the RV32I field rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    typedef int unsigned uint_t;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm;
    } fieldT;

    typedef struct {
        logic [31:0] instr;
        int          acceptCyc;
    } expT;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_if #(.XLEN(32), .ADDR_W(32)) bus ();
    instr_encoder_if #(.XLEN(32), .ADDR_W(4))  wbus ();

    instr_encoder #(.XLEN(32), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    instr_encoder #(.XLEN(32), .ADDR_W(4), .BASE_ADDR(4'd12)) dutWrap (
        .clk  (clk),
        .rstn (rstn),
        .bus  (wbus)
    );

    int          compareCount = 0;
    int          mismatchCount = 0;
    int          cycle = 0;
    bit          checkLatency = 0;
    bit          lastAccepted = 0;
    expT         expQ[$];
    int          errQ[$];
    logic [31:0] goldQ[$];
    logic [3:0]  wrapAddrs[$];
    logic [31:0] expAddr = 32'h0;
    int          expCount = 0;
    int          lastErr = 0;
    fieldT       curFields;

    logic [6:0] opList [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F};

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic uint_t fld(input uint_t u, input int hi, input int lo);
        return (u >> lo) & ((uint_t'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Reference encoder working from the ISA field rules.
    function automatic void refModel(input fieldT f, output logic [31:0] word, output int code);
        uint_t u, rdp, rs1p, rs2p, f3p, opp;
        u    = uint_t'(f.imm);
        rdp  = uint_t'(f.rd) << 7;
        rs1p = uint_t'(f.rs1) << 15;
        rs2p = uint_t'(f.rs2) << 20;
        f3p  = uint_t'(f.f3) << 12;
        opp  = uint_t'(f.op);
        word = 32'h0;
        code = 0;
        case (f.op)
            7'h33: word = (uint_t'(f.f7) << 25) | rs2p | rs1p | f3p | rdp | opp;
            7'h13, 7'h03, 7'h67: begin
                if (f.imm < -2048 || f.imm > 2047) code = 1;
                word = (fld(u, 11, 0) << 20) | rs1p | f3p | rdp | opp;
            end
            7'h23: begin
                if (f.imm < -2048 || f.imm > 2047) code = 1;
                word = (fld(u, 11, 5) << 25) | rs2p | rs1p | f3p | (fld(u, 4, 0) << 7) | opp;
            end
            7'h63: begin
                if (f.imm % 2 != 0) code = 2;
                else if (f.imm < -4096 || f.imm > 4095) code = 1;
                word = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | rs2p | rs1p | f3p
                     | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7) | opp;
            end
            7'h37, 7'h17: begin
                if (u % 4096 != 0) code = 1;
                word = ((u / 4096) * 4096) | rdp | opp;
            end
            7'h6F: begin
                if (f.imm % 2 != 0) code = 2;
                else if (f.imm < -(1 << 20) || f.imm > (1 << 20) - 1) code = 1;
                word = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20)
                     | (fld(u, 19, 12) << 12) | rdp | opp;
            end
            default: code = 3;
        endcase
    endfunction

    function automatic fieldT mk(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input int imm);
        fieldT f;
        f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.f3 = f3;
        f.f7 = 7'h0; f.imm = imm;
        return f;
    endfunction

    function automatic fieldT randFields();
        fieldT f;
        int    sel;
        f.op  = opList[$urandom_range(0, 9)];
        f.rd  = 5'($urandom);
        f.rs1 = 5'($urandom);
        f.rs2 = 5'($urandom);
        f.f3  = 3'($urandom);
        f.f7  = 7'($urandom);
        sel   = int'($urandom_range(0, 5));
        case (sel)
            0: f.imm = int'($urandom_range(0, 127)) - 64;
            1: f.imm = 2040 + int'($urandom_range(0, 15));
            2: f.imm = 4088 + int'($urandom_range(0, 15));
            3: f.imm = (1 << 20) - 8 + int'($urandom_range(0, 15));
            4: f.imm = int'($urandom);
            default: begin
                f.imm = int'($urandom & 32'hFFFF_F000);
                if ($urandom_range(0, 3) == 0) f.imm = f.imm | (1 << $urandom_range(0, 11));
            end
        endcase
        if (sel >= 1 && sel <= 3 && $urandom_range(0, 1) == 1) f.imm = -f.imm;
        return f;
    endfunction

    task automatic applyStimulus(input fieldT f);
        curFields    = f;
        bus.opcode   = f.op;
        bus.rd       = f.rd;
        bus.rs1      = f.rs1;
        bus.rs2      = f.rs2;
        bus.funct3   = f.f3;
        bus.funct7   = f.f7;
        bus.imm      = f.imm;
        bus.in_valid = 1'b1;
    endtask

    // One clock: score everything visible at the falling edge, then return
    // just after the next rising edge so inputs can be changed.
    task automatic tick();
        expT         e;
        logic [31:0] w;
        int          code;
        @(negedge clk);
        cycle++;
        lastAccepted = 0;
        if (bus.out_valid && bus.out_ready && !bus.clr) begin
            checkOutput("word expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("out_instr", bus.out_instr, e.instr);
                checkOutput("out_addr", bus.out_addr, expAddr);
                if (checkLatency) checkOutput("latency", cycle - e.acceptCyc, 32'd2);
            end
            if (goldQ.size() > 0) checkOutput("golden word", bus.out_instr, goldQ.pop_front());
            expAddr += 4;
            expCount++;
        end
        if (bus.err_valid) begin
            checkOutput("error expected", 32'(errQ.size() > 0), 32'd1);
            if (errQ.size() > 0) begin
                code = errQ.pop_front();
                checkOutput("err_code", bus.err_code, code);
                lastErr = code;
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            lastAccepted = 1;
            refModel(curFields, w, code);
            if (code == 0) expQ.push_back('{w, cycle});
            else errQ.push_back(code);
        end
        if (wbus.out_valid && wbus.out_ready) wrapAddrs.push_back(wbus.out_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic flushModel();
        expQ.delete();
        errQ.delete();
        goldQ.delete();
        expAddr  = 32'h0;
        expCount = 0;
    endtask

    initial begin
        fieldT       dirF[5];
        logic [31:0] dirW[5];
        fieldT       bpF[4];
        logic [31:0] heldInstr, heldAddr;
        int          idx;

        bus.clr = 0; bus.in_valid = 0; bus.out_ready = 1;
        bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        wbus.clr = 0; wbus.in_valid = 0; wbus.out_ready = 1;
        wbus.opcode = 7'h13; wbus.rd = 5'd1; wbus.rs1 = '0; wbus.rs2 = '0;
        wbus.funct3 = '0; wbus.funct7 = '0; wbus.imm = 32'd5;

        // Reset values.
        #2;
        checkOutput("rst out_valid", bus.out_valid, 0);
        checkOutput("rst in_ready", bus.in_ready, 0);
        checkOutput("rst out_instr", bus.out_instr, 0);
        checkOutput("rst out_addr", bus.out_addr, 0);
        checkOutput("rst err_valid", bus.err_valid, 0);
        checkOutput("rst err_code", bus.err_code, 0);
        checkOutput("rst word_count", bus.word_count, 0);
        #10 rstn = 1'b1;
        #1 checkOutput("in_ready before first clock", bus.in_ready, 0);
        @(posedge clk); #1;
        checkOutput("in_ready after first clock", bus.in_ready, 1);

        // Directed encodings, no backpressure.
        dirF[0] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 5);            dirW[0] = 32'h0050_0093;
        dirF[1] = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 8);            dirW[1] = 32'h0020_A423;
        dirF[2] = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -4);           dirW[2] = 32'hFE00_0EE3;
        dirF[3] = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 8);            dirW[3] = 32'h0080_00EF;
        dirF[4] = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000); dirW[4] = 32'h1234_52B7;
        checkLatency = 1;
        for (int i = 0; i < 5; i++) begin
            goldQ.push_back(dirW[i]);
            applyStimulus(dirF[i]);
            tick();
        end
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        checkLatency = 0;
        checkOutput("directed word_count", bus.word_count, 32'd5);
        checkOutput("directed drained", 32'(expQ.size()), 0);

        // Rejected inputs: misaligned branch, out-of-range addi, bad opcode.
        begin
            fieldT errF[3];
            int    errC[3];
            errF[0] = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 3);    errC[0] = 2;
            errF[1] = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 2048); errC[1] = 1;
            errF[2] = mk(7'h0F, 5'd0, 5'd0, 5'd0, 3'd0, 0);    errC[2] = 3;
            for (int i = 0; i < 3; i++) begin
                applyStimulus(errF[i]);
                tick();
                bus.in_valid = 0;
                for (int k = 0; k < 4; k++) tick();
                checkOutput("err_code held", bus.err_code, errC[i]);
                checkOutput("err_valid is a pulse", bus.err_valid, 0);
                checkOutput("error reported", 32'(errQ.size()), 0);
                checkOutput("addr unchanged by error", bus.out_addr, expAddr);
            end
        end

        // Backpressure: 4 words with the consumer stalled for 5 cycles.
        for (int i = 0; i < 4; i++) bpF[i] = mk(7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0, 100 + i);
        bus.out_ready = 0;
        idx = 0;
        heldInstr = '0; heldAddr = '0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) applyStimulus(bpF[idx]);
            tick();
            if (lastAccepted) idx++;
            if (c >= 1) checkOutput("bp in_ready low", bus.in_ready, 0);
            if (c == 1) begin
                heldInstr = bus.out_instr;
                heldAddr  = bus.out_addr;
            end
            if (c >= 2) begin
                checkOutput("bp out_instr stable", bus.out_instr, heldInstr);
                checkOutput("bp out_addr stable", bus.out_addr, heldAddr);
            end
        end
        bus.out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) applyStimulus(bpF[idx]);
            else bus.in_valid = 0;
            tick();
            if (lastAccepted) idx++;
        end
        bus.in_valid = 0;
        checkOutput("bp all accepted", idx, 4);
        checkOutput("bp drained", 32'(expQ.size()), 0);

        // Randomized stream with random backpressure.
        for (int c = 0; c < 400; c++) begin
            if (!bus.in_valid || lastAccepted) begin
                if ($urandom_range(0, 3) != 0) applyStimulus(randFields());
                else bus.in_valid = 0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("rand words drained", 32'(expQ.size()), 0);
        checkOutput("rand errors drained", 32'(errQ.size()), 0);
        checkOutput("rand word_count", bus.word_count, 32'(expCount & 16'hFFFF));
        checkOutput("rand out_addr", bus.out_addr, expAddr);

        // clr with a full pipeline and an input on offer.
        bus.out_ready = 0;
        applyStimulus(mk(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 1)); tick();
        applyStimulus(mk(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 2)); tick();
        applyStimulus(mk(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 3));
        bus.clr = 1;
        bus.out_ready = 1;
        #1 checkOutput("in_ready during clr", bus.in_ready, 0);
        tick();
        bus.clr = 0;
        bus.in_valid = 0;
        flushModel();
        checkOutput("clr out_valid", bus.out_valid, 0);
        checkOutput("clr out_addr", bus.out_addr, 0);
        checkOutput("clr word_count", bus.word_count, 0);
        checkOutput("clr keeps err_code", bus.err_code, lastErr);
        applyStimulus(mk(7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7)); tick();
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("post-clr word_count", bus.word_count, 1);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(7'h13, 5'(i + 7), 5'd1, 5'd0, 3'd0, i));
            tick();
        end
        #2 rstn = 1'b0;
        #1;
        checkOutput("mid-rst out_valid", bus.out_valid, 0);
        checkOutput("mid-rst in_ready", bus.in_ready, 0);
        checkOutput("mid-rst out_instr", bus.out_instr, 0);
        checkOutput("mid-rst out_addr", bus.out_addr, 0);
        checkOutput("mid-rst word_count", bus.word_count, 0);
        checkOutput("mid-rst err_code", bus.err_code, 0);
        bus.in_valid = 0;
        flushModel();
        lastErr = 0;
        @(negedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-rst in_ready", bus.in_ready, 1);
        applyStimulus(mk(7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCD_E000)); tick();
        bus.in_valid = 0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("post-rst word_count", bus.word_count, 1);

        // Address wrap on the 4-bit instance starting at 12.
        wbus.in_valid = 1;
        tick();
        tick();
        wbus.in_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("wrap word total", 32'(wrapAddrs.size()), 2);
        checkOutput("wrap first addr", (wrapAddrs.size() > 0) ? 32'(wrapAddrs[0]) : 32'hFFFF_FFFF, 12);
        checkOutput("wrap second addr", (wrapAddrs.size() > 1) ? 32'(wrapAddrs[1]) : 32'hFFFF_FFFF, 0);
        checkOutput("wrap word_count", wbus.word_count, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the immediate generator.
- Accepts decoded fields (opcode, registers, funct, full-width immediate) and packs them into a 32-bit instruction word, with immediate bit-scatter per I/S/B/U/J format.
- Range-checks each immediate and emits each legal word with a sequential instruction-memory write address.
- Used by the self-test/boot sequencer to build programs in instruction memory.

Parameters:
- XLEN, 32, width of the imm input.
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, first write address after reset or clr.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush: empties pipeline, reloads address and count.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- opcode  in  7  instruction opcode.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used only for OP 0110011.
- imm  in  XLEN  unpacked signed immediate (byte offset for B/J; full value for U).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  write address of out_instr.
- err_valid  out  1  one-cycle pulse: an input was rejected.
- err_code  out  2  reason code; held until the next error.
- word_count  out  16  number of words delivered, wraps at 65535 -> 0.

Behaviour:
- Reset (rstn low, async): out_valid=0, in_ready=0 while asserted, out_instr=0, out_addr=BASE_ADDR, err_valid=0, err_code=0, word_count=0, S1 empty.
- in_ready=1 from the first clock after reset deassertion, subject to the flow-control rule below.

Pipeline (two stages):
- S1 captures fields on in_valid & in_ready, then decodes format and runs the range check.
- S2 is the output register holding the encoded word.
- Latency is exactly 2 cycles from the accept edge to out_valid, when there is no backpressure.
- Throughput is 1 word per cycle.
- S2 loads when !out_valid | out_ready.
- S1 advances under the same condition.
- in_ready = !s1_full | s2_loads. It is combinational on out_ready; no bubble is inserted under continuous flow.
- While out_valid=1 and out_ready=0: out_instr and out_addr are held stable.

Formats:
- I (0010011, 0000011, 1100111): imm[11:0] -> [31:20].
- S (0100011): imm[11:5] -> [31:25], imm[4:0] -> [11:7].
- B (1100011): imm[12|10:5] -> [31:25], imm[4:1|11] -> [11:7].
- U (0110111, 0010111): imm[31:12] -> [31:12].
- J (1101111): imm[20|10:1|11|19:12] -> [31:12].
- R (0110011): funct7 -> [31:25].
- Field placement: rd -> [11:7] (R/I/U/J), rs1 -> [19:15], rs2 -> [24:20], funct3 -> [14:12].
- Fields not used by the format are ignored.
- For I-type shifts (funct3 001/101), imm[11:5] is passed through unchanged.

Range check (evaluated in S1):
- I/S: imm must equal sign-extension of imm[11:0].
- B: imm must equal sign-extension of imm[12:0], and imm[0] must be 0.
- J: imm must equal sign-extension of imm[20:0], and imm[0] must be 0.
- U: imm[11:0] must be 0.
- Error codes: 1 = out of range; 2 = misaligned (B/J with imm[0]=1; checked first); 3 = unsupported opcode.

Error handling:
- A failing entry is dropped at S1 advance; nothing is written to S2.
- err_valid pulses for 1 cycle and err_code updates in the same cycle.
- out_addr and word_count are not advanced for the dropped entry.

Address and count:
- out_addr advances by 4 on each out_valid & out_ready handshake.
- out_addr wraps modulo 2^ADDR_W.
- word_count increments on the same handshake.

clr:
- clr wins over everything else in its cycle.
- in_ready=0 during clr; S1 and S2 are emptied.
- Next cycle: out_valid=0, out_addr=BASE_ADDR, word_count=0; err_code is kept.
- A handshake in the clr cycle is discarded: not counted, address not advanced.

Reset mid-stream: in-flight words are lost and all outputs return to their reset values immediately.

Test Plan:
- Encode, no backpressure: addi x1,x0,5 -> 0x00500093; sw x2,8(x1) -> 0x0020A423; beq x0,x0,-4 -> 0xFE000EE3; jal x1,8 -> 0x008000EF; lui x5,0x12345000 -> 0x123452B7. Required: out_addr 0,4,8,12,16; each word appears 2 cycles after its accept; word_count=5.
- Errors: beq with imm=3 -> err_valid pulse, err_code=2, no output word. addi with imm=2048 -> err_code=1. Opcode 0001111 -> err_code=3. In all three, out_addr is unchanged.
- Backpressure: stream 4 words with out_ready=0 for 5 cycles. Required: in_ready falls once S1 and S2 are both full; out_instr/out_addr stay stable; after release all 4 words arrive in order, nothing lost or duplicated.
- Wrap: ADDR_W=4, BASE_ADDR=12. Two words -> out_addr 12, then 0.
- clr with a full pipeline and in_valid high -> next cycle out_valid=0, out_addr=BASE_ADDR, word_count=0; the input offered in the clr cycle is not accepted.
- rstn pulsed low mid-stream (asynchronously, between edges) -> outputs immediately at reset values; the first accept after release yields out_addr=BASE_ADDR.
